// File: rtl/vram_arbiter.sv
// VRAM arbiter: the video fetch gets a fixed read slot in pixel phase 01 during active
// lines. The CPU (host 0) and the blitter (host 1) share every other cycle round-robin.
// Host ops take two cycles: issue in IDLE, then capture the response in RESP.
module vram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_phase,
    input  logic                  i_vblank,
    input  logic [ADDR_W-1:0]     i_vid_addr,
    output logic [DATA_W-1:0]     o_vid_data,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  logic [2*ADDR_W-1:0]   i_addr,
    input  logic [2*DATA_W-1:0]   i_wdata,
    output logic [1:0]            o_ack,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    input  logic [DATA_W-1:0]     i_ram_rdata
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RESP = 1'b1;

    logic [ADDR_W-1:0] host_addr  [2];
    logic [DATA_W-1:0] host_wdata [2];

    // Unpack the per-host address and write-data buses.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_host
            assign host_addr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
            assign host_wdata[gi] = i_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic              state_reg, state_next;
    logic              last_reg, last_next;
    logic              gnt_reg, gnt_next;
    logic              gnt_we_reg, gnt_we_next;
    logic              vid_pend_reg;
    logic [1:0]        ack_reg, ack_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [DATA_W-1:0] vid_data_reg;

    logic video_slot;
    logic host_go;
    logic gnt_sel;

    assign video_slot = (i_phase == 2'b01) && !i_vblank;
    assign host_go    = (state_reg == ST_IDLE) && !video_slot && (|i_req);
    // A lone requester wins; on a tie the host that did not go last wins.
    assign gnt_sel    = (i_req == 2'b11) ? ~last_reg : i_req[1];

    // RAM port mux: video read in its slot, otherwise a freshly granted host op.
    // Held quiet during reset so an abandoned op never reaches the macro.
    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (!i_rst) begin
            if (video_slot) begin
                o_ram_en   = 1'b1;
                o_ram_addr = i_vid_addr;
            end else if (host_go) begin
                o_ram_en    = 1'b1;
                o_ram_we    = i_we[gnt_sel];
                o_ram_addr  = host_addr[gnt_sel];
                o_ram_wdata = host_wdata[gnt_sel];
            end
        end
    end

    // Next-state logic for the issue/response FSM and the round-robin pointer.
    always_comb begin
        state_next  = state_reg;
        last_next   = last_reg;
        gnt_next    = gnt_reg;
        gnt_we_next = gnt_we_reg;
        ack_next    = 2'b00;
        rdata_next  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (host_go) begin
                    state_next  = ST_RESP;
                    gnt_next    = gnt_sel;
                    gnt_we_next = i_we[gnt_sel];
                    last_next   = gnt_sel;
                end
            end
            default: begin
                // RAM data for the op issued last cycle is on i_ram_rdata now.
                ack_next   = gnt_reg ? 2'b10 : 2'b01;
                rdata_next = gnt_we_reg ? '0 : i_ram_rdata;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; video data is captured the cycle after its slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            last_reg     <= 1'b1;
            gnt_reg      <= 1'b0;
            gnt_we_reg   <= 1'b0;
            ack_reg      <= 2'b00;
            rdata_reg    <= '0;
            vid_pend_reg <= 1'b0;
            vid_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            gnt_reg      <= gnt_next;
            gnt_we_reg   <= gnt_we_next;
            ack_reg      <= ack_next;
            rdata_reg    <= rdata_next;
            vid_pend_reg <= video_slot;
            if (vid_pend_reg) begin
                vid_data_reg <= i_ram_rdata;
            end
        end
    end

    assign o_ack      = ack_reg;
    assign o_rdata    = rdata_reg;
    assign o_vid_data = vid_data_reg;

endmodule
